alu_operand_stage: RTL

- Registered operand stage between decode and the ALU: a parametrised successor to the decode-to-ALU operand bundle.
- Carries operands a/b, carry-in and condition register with a valid/ready handshake and a 2-entry skid buffer.
- Forwards results from NFWD writeback sources, both on capture and while operands are held during stalls.
- Supports pipeline flush.

---
 rtl/alu_operand_stage_pkg.sv | 21 ++
 rtl/alu_operand_stage_fwd_mux.sv | 30 +++
 rtl/alu_operand_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared constants and the operand-entry layout for the decode-to-ALU operand stage.
package alu_operand_stage_pkg;

    localparam int unsigned ALU_OPERAND_W   = 32;
    localparam int unsigned ALU_REG_AW      = 5;
    localparam int unsigned ALU_FWD_SOURCES = 2;

    // Entry layout at the default widths; the stage builds the same layout at its own widths.
    typedef struct packed {
        logic                     valid;
        logic [ALU_OPERAND_W-1:0] a;
        logic [ALU_OPERAND_W-1:0] b;
        logic [ALU_REG_AW-1:0]    src_a;
        logic [ALU_REG_AW-1:0]    src_b;
        logic                     fwd_en_a;
        logic                     fwd_en_b;
        logic                     cin;
        logic [ALU_OPERAND_W-1:0] cr;
    } operand_entry_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Priority forwarding select: the lowest-indexed matching writeback source replaces the value.
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned W    = ALU_OPERAND_W,
    parameter int unsigned NFWD = ALU_FWD_SOURCES,
    parameter int unsigned AW   = ALU_REG_AW
) (
    input  logic [W-1:0]             value,
    input  logic [AW-1:0]            src,
    input  logic                     en,
    input  logic [NFWD-1:0]          fwd_valid,
    input  logic [NFWD-1:0][AW-1:0]  fwd_dest,
    input  logic [NFWD-1:0][W-1:0]   fwd_data,
    output logic [W-1:0]             result
);

    // Walk from the oldest source down so the youngest match is written last.
    always_comb begin
        result = value;
        if (en) begin
            for (int i = int'(NFWD) - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_dest[i] == src)) begin
                    result = fwd_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage between decode and the ALU: head entry drives the ALU, a skid
// entry absorbs one extra operation, and both keep snooping writeback results while held.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned W    = ALU_OPERAND_W,
    parameter int unsigned NFWD = ALU_FWD_SOURCES,
    parameter int unsigned AW   = ALU_REG_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [W-1:0]             dec_a,
    input  logic [W-1:0]             dec_b,
    input  logic [AW-1:0]            dec_src_a,
    input  logic [AW-1:0]            dec_src_b,
    input  logic                     dec_fwd_en_a,
    input  logic                     dec_fwd_en_b,
    input  logic                     dec_cin,
    input  logic [W-1:0]             dec_cr,
    input  logic [NFWD-1:0]          fwd_valid,
    input  logic [NFWD-1:0][AW-1:0]  fwd_dest,
    input  logic [NFWD-1:0][W-1:0]   fwd_data,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic                     alu_cin,
    output logic [W-1:0]             alu_cr
);

    typedef struct packed {
        logic          valid;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] src_a;
        logic [AW-1:0] src_b;
        logic          fwd_en_a;
        logic          fwd_en_b;
        logic          cin;
        logic [W-1:0]  cr;
    } entry_t;

    entry_t h_q, h_d, s_q, s_d;
    entry_t new_e, h_held, s_held;

    logic [W-1:0] cap_a, cap_b, h_fwd_a, h_fwd_b, s_fwd_a, s_fwd_b;
    logic         accept, consume;

    assign dec_ready = ~s_q.valid;
    assign accept    = dec_valid & dec_ready & ~flush;
    assign consume   = h_q.valid & alu_ready;

    assign alu_valid = h_q.valid;
    assign alu_a     = h_q.a;
    assign alu_b     = h_q.b;
    assign alu_cin   = h_q.cin;
    assign alu_cr    = h_q.cr;

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_cap_a (
        .value(dec_a), .src(dec_src_a), .en(dec_fwd_en_a),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(cap_a)
    );

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_cap_b (
        .value(dec_b), .src(dec_src_b), .en(dec_fwd_en_b),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(cap_b)
    );

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_hold_h_a (
        .value(h_q.a), .src(h_q.src_a), .en(h_q.fwd_en_a),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(h_fwd_a)
    );

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_hold_h_b (
        .value(h_q.b), .src(h_q.src_b), .en(h_q.fwd_en_b),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(h_fwd_b)
    );

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_hold_s_a (
        .value(s_q.a), .src(s_q.src_a), .en(s_q.fwd_en_a),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(s_fwd_a)
    );

    alu_operand_stage_fwd_mux #(.W(W), .NFWD(NFWD), .AW(AW)) u_hold_s_b (
        .value(s_q.b), .src(s_q.src_b), .en(s_q.fwd_en_b),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .result(s_fwd_b)
    );

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.a        = cap_a;
        new_e.b        = cap_b;
        new_e.src_a    = dec_src_a;
        new_e.src_b    = dec_src_b;
        new_e.fwd_en_a = dec_fwd_en_a;
        new_e.fwd_en_b = dec_fwd_en_b;
        new_e.cin      = dec_cin;
        new_e.cr       = dec_cr;

        h_held   = h_q;
        h_held.a = h_fwd_a;
        h_held.b = h_fwd_b;
        s_held   = s_q;
        s_held.a = s_fwd_a;
        s_held.b = s_fwd_b;
    end

    always_comb begin
        h_d = h_held;
        s_d = s_held;
        if (flush) begin
            h_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (consume || !h_q.valid) begin
            // Head slot frees up: skid entry (with its own forwarding applied) moves forward.
            if (s_q.valid) begin
                h_d = s_held;
                if (accept) begin
                    s_d = new_e;
                end else begin
                    s_d.valid = 1'b0;
                end
            end else if (accept) begin
                h_d = new_e;
            end else begin
                h_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = new_e;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_q <= '0;
            s_q <= '0;
        end else begin
            h_q <= h_d;
            s_q <= s_d;
        end
    end

    a_no_accept_when_full: assert property (@(posedge clk) disable iff (!reset)
        accept |-> !s_q.valid);

    a_no_x_on_alu: assert property (@(posedge clk) disable iff (!reset)
        h_q.valid |-> !$isunknown({alu_a, alu_b, alu_cin, alu_cr}));

endmodule
